// File: rtl/conv_host_pkg.sv
// Shared types and constants for the Convolution host-side controller.
package conv_host_pkg;

   localparam int unsigned IFM_LANES  = 32;
   localparam int unsigned IFM_BITS   = 4;
   localparam int unsigned OFM_BITS   = 13;
   localparam int unsigned IFM_WORD_W = IFM_LANES * IFM_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Lane i occupies bits [4i+3:4i].
   typedef logic [IFM_LANES-1:0][IFM_BITS-1:0] ifm_word_t;

endpackage

// File: rtl/conv_result_buf.sv
// Result storage: one write port, one registered read port with a valid flag.
module conv_result_buf
   import conv_host_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [OFM_BITS-1:0] wr_data,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_addr,
   output logic [OFM_BITS-1:0] rd_data,
   output logic                rd_valid
);

   logic [OFM_BITS-1:0] mem [DEPTH];

   // Storage survives reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read data holds when no read is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= mem[rd_addr];
         end
      end
   end

endmodule

// File: rtl/conv_host_ctrl.sv
// Host-side controller: streams a preloaded IFM frame into the Convolution core
// and captures its OFM results, flagging completion, timeout and overflow.
module conv_host_ctrl
   import conv_host_pkg::*;
#(
   parameter int unsigned FRAME_BEATS = 32,
   parameter int unsigned OUT_COUNT   = 32,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             host_wr_en,
   input  logic [$clog2(FRAME_BEATS)-1:0]   host_wr_addr,
   input  logic [IFM_WORD_W-1:0]            host_wr_data,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             err_timeout,
   output logic                             err_overflow,
   output logic [$clog2(OUT_COUNT+1)-1:0]   res_count,
   input  logic                             res_rd_en,
   input  logic [$clog2(OUT_COUNT)-1:0]     res_rd_addr,
   output logic [OFM_BITS-1:0]              res_rd_data,
   output logic                             res_rd_valid,
   output logic                             in_valid,
   output logic [IFM_BITS-1:0]              In_IFM [0:IFM_LANES-1],
   input  logic                             out_valid,
   input  logic [OFM_BITS-1:0]              Out_OFM
);

   localparam int unsigned BEAT_W = $clog2(FRAME_BEATS);
   localparam int unsigned CNT_W  = $clog2(OUT_COUNT + 1);
   localparam int unsigned RES_AW = $clog2(OUT_COUNT);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [CNT_W-1:0]    res_count_d;
   logic                err_to_d, err_ov_d;
   logic                leave_wait, start_ok, cap_en, wait_full, wait_expired;
   ifm_word_t           ifm_q, ifm_d;
   ifm_word_t           ifm_buf [FRAME_BEATS];

   // IFM buffer: host writes only land while idle and not starting.
   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && host_wr_en && !start) begin
         ifm_buf[host_wr_addr] <= host_wr_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      idle_d      = idle_q;
      res_count_d = res_count;
      err_to_d    = err_timeout;
      err_ov_d    = err_overflow;
      leave_wait  = 1'b0;
      start_ok    = 1'b0;
      cap_en      = 1'b0;
      ifm_d       = '0;

      wait_full    = (res_count == CNT_W'(OUT_COUNT));
      wait_expired = (idle_q == IDLE_W'(TIMEOUT));

      case (state_q)
         IDLE: begin
            if (start) begin
               start_ok = 1'b1;
               beat_d   = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (beat_q == BEAT_W'(FRAME_BEATS - 1)) begin
               state_d = WAIT;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         WAIT: begin
            if (wait_full || wait_expired) begin
               leave_wait = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A result in the terminating WAIT cycle is dropped like any other overflow.
      cap_en = out_valid && !wait_full &&
               ((state_q == SEND) || ((state_q == WAIT) && !leave_wait));

      if (start_ok) begin
         res_count_d = '0;
         err_to_d    = 1'b0;
         err_ov_d    = 1'b0;
      end else if (cap_en) begin
         res_count_d = res_count + CNT_W'(1);
      end

      if (out_valid && !cap_en) begin
         err_ov_d = 1'b1;
      end
      if (leave_wait && !wait_full) begin
         err_to_d = 1'b1;
      end

      // Idle counter lives only in WAIT and saturates at TIMEOUT.
      if ((state_q != WAIT) || out_valid) begin
         idle_d = '0;
      end else if (!wait_expired) begin
         idle_d = idle_q + IDLE_W'(1);
      end

      if (state_d == SEND) begin
         ifm_d = ifm_buf[beat_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         idle_q       <= '0;
         res_count    <= '0;
         err_timeout  <= 1'b0;
         err_overflow <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         in_valid     <= 1'b0;
         ifm_q        <= '0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         idle_q       <= idle_d;
         res_count    <= res_count_d;
         err_timeout  <= err_to_d;
         err_overflow <= err_ov_d;
         busy         <= (state_d != IDLE);
         done         <= leave_wait;
         in_valid     <= (state_d == SEND);
         ifm_q        <= ifm_d;
      end
   end

   always_comb begin
      for (int i = 0; i < IFM_LANES; i++) begin
         In_IFM[i] = ifm_q[i];
      end
   end

   conv_result_buf #(
      .DEPTH (OUT_COUNT)
   ) u_res_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (cap_en),
      .wr_addr  (res_count[RES_AW-1:0]),
      .wr_data  (Out_OFM),
      .rd_en    (res_rd_en),
      .rd_addr  (res_rd_addr),
      .rd_data  (res_rd_data),
      .rd_valid (res_rd_valid)
   );

endmodule

// File: tb/tb_conv_host_ctrl.sv
// Directed self-checking bench for conv_host_ctrl (TIMEOUT shortened to 16).
module tb_conv_host_ctrl;

   localparam int unsigned FB     = 32;
   localparam int unsigned OC     = 32;
   localparam int unsigned TO     = 16;
   localparam int          BUDGET = 80;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         host_wr_en;
   logic [4:0]   host_wr_addr;
   logic [127:0] host_wr_data;
   logic         start;
   logic         busy, done, err_timeout, err_overflow;
   logic [5:0]   res_count;
   logic         res_rd_en;
   logic [4:0]   res_rd_addr;
   logic [12:0]  res_rd_data;
   logic         res_rd_valid;
   logic         in_valid;
   logic [3:0]   In_IFM [0:31];
   logic         out_valid;
   logic [12:0]  Out_OFM;

   logic [127:0] exp_ifm [FB];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   conv_host_ctrl #(
      .FRAME_BEATS (FB),
      .OUT_COUNT   (OC),
      .TIMEOUT     (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .err_timeout  (err_timeout),
      .err_overflow (err_overflow),
      .res_count    (res_count),
      .res_rd_en    (res_rd_en),
      .res_rd_addr  (res_rd_addr),
      .res_rd_data  (res_rd_data),
      .res_rd_valid (res_rd_valid),
      .in_valid     (in_valid),
      .In_IFM       (In_IFM),
      .out_valid    (out_valid),
      .Out_OFM      (Out_OFM)
   );

   function automatic logic [12:0] res_val(input int r);
      return 13'((r * 263 + 17) % 8192);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input int addr, input logic [12:0] exp);
      res_rd_en   = 1'b1;
      res_rd_addr = 5'(addr);
      @(negedge clk);
      res_rd_en = 1'b0;
      chk($sformatf("rd_valid[%0d]", addr), 64'(res_rd_valid), 64'd1);
      chk($sformatf("rd_data[%0d]", addr), 64'(res_rd_data), 64'(exp));
      @(negedge clk);
      chk($sformatf("rd_hold[%0d]", addr), 64'(res_rd_data), 64'(exp));
   endtask

   // One frame: core returns n results from frame cycle rs; guard_j injects start+write.
   task automatic frame(input string name, input int rs, input int n,
                        input int guard_j, input int exp_done_j);
      int burst, bad, done_cnt, done_j;
      logic [127:0] w;
      burst = 0; bad = 0; done_cnt = 0; done_j = -1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, " busy_rise"}, 64'(busy), 64'd1);
      chk({name, " ovf_clr"}, 64'(err_overflow), 64'd0);
      chk({name, " to_clr"}, 64'(err_timeout), 64'd0);
      chk({name, " cnt_clr"}, 64'(res_count), 64'd0);
      for (int j = 0; j < BUDGET; j++) begin
         if (in_valid === 1'b1) burst++;
         if (in_valid !== (j < 32)) bad++;
         w = (j < 32) ? exp_ifm[j] : '0;
         for (int i = 0; i < 32; i++) begin
            if (In_IFM[i] !== w[4*i +: 4]) bad++;
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_j < 0) done_j = j;
         end
         out_valid    = (j >= rs) && (j < rs + n);
         Out_OFM      = out_valid ? res_val(j - rs) : 13'd0;
         start        = (j == guard_j);
         host_wr_en   = (j == guard_j);
         host_wr_addr = 5'd7;
         host_wr_data = '1;
         @(negedge clk);
      end
      out_valid = 1'b0; start = 1'b0; host_wr_en = 1'b0;
      chk({name, " burst_len"}, 64'(burst), 64'd32);
      chk({name, " burst_data"}, 64'(bad), 64'd0);
      chk({name, " done_pulses"}, 64'(done_cnt), 64'd1);
      chk({name, " done_cycle"}, 64'(done_j), 64'(exp_done_j));
      chk({name, " busy_fall"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int nz;
      logic [127:0] w;
      rst_n = 1'b1; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      start = 1'b0; res_rd_en = 1'b0; res_rd_addr = '0; out_valid = 1'b0; Out_OFM = '0;
      #2 rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      nz = 0;
      for (int i = 0; i < 32; i++) if (In_IFM[i] !== 4'h0) nz++;
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst in_valid", 64'(in_valid), 64'd0);
      chk("rst ifm", 64'(nz), 64'd0);
      chk("rst res_count", 64'(res_count), 64'd0);
      chk("rst errs", 64'({err_timeout, err_overflow}), 64'd0);
      chk("rst rd_valid", 64'(res_rd_valid), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 32; k++) begin
         w = {32{4'(k)}};
         exp_ifm[k]   = w;
         host_wr_en   = 1'b1;
         host_wr_addr = 5'(k);
         host_wr_data = w;
         @(negedge clk);
      end
      host_wr_en = 1'b0;

      // Results j=34..65, count=32 seen at 66, done at 67.
      frame("nominal", 34, 32, -1, 67);
      chk("nominal res_count", 64'(res_count), 64'd32);
      chk("nominal errs", 64'({err_timeout, err_overflow}), 64'd0);
      rd_chk(5, res_val(5));
      rd_chk(31, res_val(31));

      // Results j=3..34, done at 36.
      frame("early", 3, 32, -1, 36);
      chk("early res_count", 64'(res_count), 64'd32);
      chk("early ovf", 64'(err_overflow), 64'd0);
      rd_chk(0, res_val(0));

      out_valid = 1'b1; Out_OFM = 13'h0AB;
      @(negedge clk);
      out_valid = 1'b0;
      chk("idle_ov flag", 64'(err_overflow), 64'd1);
      chk("idle_ov count", 64'(res_count), 64'd32);
      rd_chk(0, res_val(0));

      // Result 10 at j=43; idle counter hits 16 at j=60; done at j=61.
      frame("timeout", 34, 10, -1, 61);
      chk("timeout flag", 64'(err_timeout), 64'd1);
      chk("timeout count", 64'(res_count), 64'd10);
      chk("timeout ovf", 64'(err_overflow), 64'd0);

      // 33rd result at j=66 coincides with termination and is dropped.
      frame("overflow", 34, 33, -1, 67);
      chk("overflow flag", 64'(err_overflow), 64'd1);
      chk("overflow count", 64'(res_count), 64'd32);
      for (int r = 0; r < 32; r++) rd_chk(r, res_val(r));

      frame("guard", 34, 32, 5, 67);
      chk("guard ovf", 64'(err_overflow), 64'd0);

      // Reset mid-SEND with beat 12 on the bus and 9 results captured.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 12; j++) begin
         out_valid = (j >= 3);
         Out_OFM   = res_val(j);
         @(negedge clk);
      end
      out_valid = 1'b0;
      chk("pre_rst in_valid", 64'(in_valid), 64'd1);
      chk("pre_rst count", 64'(res_count), 64'd9);
      rst_n = 1'b0;
      @(negedge clk);
      nz = 0;
      for (int i = 0; i < 32; i++) if (In_IFM[i] !== 4'h0) nz++;
      chk("mid_rst in_valid", 64'(in_valid), 64'd0);
      chk("mid_rst ifm", 64'(nz), 64'd0);
      chk("mid_rst busy", 64'(busy), 64'd0);
      chk("mid_rst count", 64'(res_count), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      frame("replay", 34, 32, -1, 67);
      chk("replay count", 64'(res_count), 64'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_host_ctrl.md
# conv_host_ctrl

Synthesizable host-side controller for the `Convolution` core; it drives the core's input side and captures its output side, so stimulus no longer comes from a behavioural pattern. A host preloads one IFM frame through a write port and pulses `start`. The block streams the frame to the core as a contiguous `in_valid` burst, then captures every `out_valid`/`Out_OFM` result into a result buffer. It flags completion, timeout and overflow conditions.

## Interface
- `FRAME_BEATS`, 32: IFM beats per frame. Each beat is 32 lanes × 4 bit.
- `OUT_COUNT`, 32: OFM results expected per frame.
- `TIMEOUT`, 1024: maximum idle cycles in WAIT between results.

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `host_wr_en`  in  1  IFM buffer write strobe
- `host_wr_addr`  in  $clog2(FRAME_BEATS)  beat index
- `host_wr_data`  in  128  lane i = bits [4i+3:4i]
- `start`  in  1  single-cycle start request
- `busy`  out  1  high in SEND and WAIT
- `done`  out  1  one-cycle completion pulse
- `err_timeout`  out  1  sticky; cleared by an accepted start
- `err_overflow`  out  1  sticky; cleared by an accepted start
- `res_count`  out  $clog2(OUT_COUNT+1)  results captured in the current/last frame
- `res_rd_en`  in  1  result read strobe
- `res_rd_addr`  in  $clog2(OUT_COUNT)  result index
- `res_rd_data`  out  13  result word
- `res_rd_valid`  out  1  high one cycle after `res_rd_en`
- `in_valid`  out  1  to core
- `In_IFM`  out  [3:0] x [31:0] unpacked  to core; all zero when `in_valid`=0
- `out_valid`  in  1  from core
- `Out_OFM`  in  13  from core, unsigned

## Operation
- States:
  - IDLE: `start` → SEND; clears `res_count` and both error flags.
  - SEND: after beat FRAME_BEATS-1 → WAIT.
  - WAIT: `res_count`==OUT_COUNT → IDLE with `done`; idle counter reaches TIMEOUT → IDLE with `done` and `err_timeout`.
- `start` is accepted only in IDLE. It is ignored while `busy`.
- `host_wr_en` is honoured only in IDLE. It is dropped when busy or in the same cycle as an accepted `start`.
- SEND drives beat k from buffer word k, k = 0..FRAME_BEATS-1, with no gaps. Lane i of the word maps to `In_IFM[i]`.
- Result capture:
  - Active in SEND and WAIT.
  - Each `out_valid` cycle writes `Out_OFM` to index `res_count`, then increments `res_count`.
- Overflow:
  - `out_valid` while `res_count`==OUT_COUNT, or while in IDLE, is dropped and sets `err_overflow`.
  - A result arriving in the same cycle as the WAIT→IDLE transition is dropped and flagged.
- Idle counter:
  - Runs only in WAIT.
  - Clears on entry to WAIT and on every `out_valid`.
  - Saturates; it does not wrap.
- Result read:
  - Allowed in any state.
  - `res_rd_data` holds its last value when no read is requested.
  - Addresses ≥ `res_count` return stale contents; this is not an error.
- Reset:
  - Asynchronous. It aborts any frame at once.
  - State goes to IDLE. All outputs and counters go to 0, and `In_IFM` goes to all zero.
  - IFM and result storage are not cleared.

## Timing
- Accepted `start` sampled at edge t → `in_valid`=1 for cycles t+1 … t+FRAME_BEATS. `busy` rises at t+1.
- All core-side and status outputs are registered.
- `done` is high for the single cycle after the terminating condition is sampled. `busy` falls in that same cycle.
- `res_count` updates the cycle after the `out_valid` it counts.
- Read latency is 1 cycle: `res_rd_en` at t → `res_rd_data`/`res_rd_valid` at t+1. Back-to-back reads are allowed.

## Structure
- Package `conv_host_pkg`:
  - constants: IFM_LANES=32, IFM_BITS=4, OFM_BITS=13
  - `typedef enum` state type: IDLE, SEND, WAIT
  - `ifm_word_t` (128 bit)
- Sub-module `conv_result_buf`: OUT_COUNT×13 storage with one write port and one registered read port.
- The IFM buffer stays inline as a FRAME_BEATS×128 register array.

## Test plan
- Nominal frame: load word k = {32{k[3:0]}}, pulse `start` → 32 contiguous `in_valid` beats with `In_IFM[i]`=k[3:0]; 32 core results captured; `done` once; `res_count`=32; read index 5 returns the 6th `Out_OFM`.
- Early results: core returns results from beat 3 of SEND onward → all 32 captured; no overflow.
- Timeout: core model stops after 10 results, TIMEOUT=16 → `done` and `err_timeout` exactly 16 idle cycles after result 10; `res_count`=10.
- Overflow: 33 results, plus one `out_valid` in IDLE → `err_overflow`=1; results 0..31 intact; next `start` clears the flag.
- Guarding: `start` and a `host_wr_en` during SEND → both ignored; burst length stays 32; buffer contents unchanged.
- Reset mid-SEND at beat 12 → next cycle `in_valid`=0, `In_IFM`=0, `busy`=0, `res_count`=0. A following `start` replays the intact IFM buffer.
